// File: rtl/board_pixel_gen_if.sv
// Board-memory read port: row fetch request/address from the pixel generator,
// row contents and valid strobe back from the memory.
interface board_pixel_gen_if #(
   parameter int COLS = 10,
   parameter int AW   = 5
);
   logic            row_req;
   logic [AW-1:0]   row_addr;
   logic [COLS-1:0] row_data;
   logic            row_valid;

   modport master (
      output row_req,
      output row_addr,
      input  row_data,
      input  row_valid
   );

   modport slave (
      input  row_req,
      input  row_addr,
      output row_data,
      output row_valid
   );
endinterface

// File: rtl/board_pixel_gen.sv
// Tetris playfield pixel generator: fetches one board row per video line, double-buffers it and
// renders cells, grid lines and blinking pending-clear rows with a two-stage pixel pipeline.
module board_pixel_gen #(
   parameter int          COLS         = 10,
   parameter int          ROWS         = 20,
   parameter int          CELL_W       = 24,
   parameter int          CELL_H       = 24,
   parameter int          X0           = 220,
   parameter int          Y0           = 0,
   parameter int          FETCH_H      = 640,
   parameter int          GRID         = 1,
   parameter int          FLASH_FRAMES = 8,
   parameter logic [23:0] ON_COLOR     = 24'hFFFFFF,
   parameter logic [23:0] OFF_COLOR    = 24'h000000,
   parameter logic [23:0] BG_COLOR     = 24'h3C3C3C,
   parameter logic [23:0] GRID_COLOR   = 24'h202020
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              bright_i,
   input  logic [9:0]        hcount_i,
   input  logic [9:0]        vcount_i,
   input  logic [ROWS-1:0]   clear_mask_i,
   board_pixel_gen_if.master mem_if,
   output logic              fetch_err_o,
   output logic [7:0]        vga_r_o,
   output logic [7:0]        vga_g_o,
   output logic [7:0]        vga_b_o
);
   localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int XW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int YW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
   localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   localparam logic [10:0]   X_LO       = 11'(X0);
   localparam logic [10:0]   X_HI       = 11'(X0 + COLS * CELL_W);
   localparam logic [10:0]   Y_LO       = 11'(Y0);
   localparam logic [10:0]   CELL_H_L   = 11'(CELL_H);
   localparam logic [10:0]   FETCH_AT   = 11'(FETCH_H);
   localparam logic [XW-1:0] SUBX_LAST  = XW'(CELL_W - 1);
   localparam logic [YW-1:0] SUBY_LAST  = YW'(CELL_H - 1);
   localparam logic [AW-1:0] ROW_LAST   = AW'(ROWS - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
   localparam logic          GRID_EN    = (GRID != 0);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [10:0]     hc_s, vnext_s, vdiff_s;
   logic            line_start_s, fetch_go_s, first_cell_s, accept_s, deadline_s;

   logic            fv_act_q, fv_act_d;
   logic [AW-1:0]   fv_row_q, fv_row_d;
   logic [YW-1:0]   fv_sub_q, fv_sub_d;
   logic [AW-1:0]   addr_q, addr_d;

   logic [COLS-1:0] shadow_q, shadow_d;
   logic            sh_line_q, sh_line_d;
   logic [AW-1:0]   sh_row_q, sh_row_d;
   logic [YW-1:0]   sh_sub_q, sh_sub_d;

   logic [COLS-1:0] act_q, act_d;
   logic            act_line_q, act_line_d;
   logic [AW-1:0]   act_row_q, act_row_d;
   logic [YW-1:0]   act_sub_q, act_sub_d;

   logic            err_q, err_d;
   logic [CW-1:0]   col_q, col_d, cur_col_s;
   logic [XW-1:0]   subx_q, subx_d, cur_subx_s;
   logic [FW-1:0]   frame_q, frame_d;
   logic            blink_q, blink_d;

   logic            s1_bright_q, s1_bright_d;
   logic            s1_inb_q, s1_inb_d;
   logic            s1_cell_q, s1_cell_d;
   logic            s1_edge_q, s1_edge_d;
   logic            s1_clr_q, s1_clr_d;
   logic [23:0]     colour_q, colour_d;

   assign hc_s         = {1'b0, hcount_i};
   assign vnext_s      = {1'b0, vcount_i} + 11'd1;
   assign vdiff_s      = vnext_s - Y_LO;
   assign line_start_s = (hcount_i == 10'd0);
   assign first_cell_s = (vdiff_s < CELL_H_L);
   assign fetch_go_s   = (state_q == ST_IDLE) && (hc_s == FETCH_AT);
   assign accept_s     = (state_q == ST_WAIT) && mem_if.row_valid;
   assign deadline_s   = (state_q == ST_WAIT) && !mem_if.row_valid && line_start_s;

   assign fetch_err_o  = err_q;
   assign vga_r_o      = colour_q[23:16];
   assign vga_g_o      = colour_q[15:8];
   assign vga_b_o      = colour_q[7:0];

   // Fetch FSM state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Fetch FSM next state; a late fetch is abandoned at the start of the line it was meant for
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch_go_s && fv_act_d) state_d = ST_WAIT;
            else                        state_d = ST_IDLE;
         end
         ST_WAIT: begin
            if (mem_if.row_valid || line_start_s) state_d = ST_IDLE;
            else                                  state_d = ST_WAIT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Fetch FSM outputs
   always_comb begin
      mem_if.row_req  = 1'b0;
      mem_if.row_addr = addr_q;
      case (state_q)
         ST_IDLE: mem_if.row_req = 1'b0;
         ST_WAIT: mem_if.row_req = 1'b1;
         default: mem_if.row_req = 1'b0;
      endcase
   end

   // Row/sub-row of the line being fetched, shadow and active line buffers
   always_comb begin
      fv_act_d   = fv_act_q;
      fv_row_d   = fv_row_q;
      fv_sub_d   = fv_sub_q;
      addr_d     = addr_q;
      shadow_d   = shadow_q;
      sh_line_d  = sh_line_q;
      sh_row_d   = sh_row_q;
      sh_sub_d   = sh_sub_q;
      act_d      = act_q;
      act_line_d = act_line_q;
      act_row_d  = act_row_q;
      act_sub_d  = act_sub_q;
      // Counters resynchronise anywhere in the first cell, so the first row needs no divider
      if (fetch_go_s) begin
         if (first_cell_s) begin
            fv_act_d = 1'b1;
            fv_row_d = '0;
            fv_sub_d = YW'(vdiff_s);
         end else if (fv_act_q) begin
            if (fv_sub_q == SUBY_LAST) begin
               fv_sub_d = '0;
               if (fv_row_q == ROW_LAST) begin
                  fv_act_d = 1'b0;
                  fv_row_d = '0;
               end else begin
                  fv_row_d = fv_row_q + AW'(1);
               end
            end else begin
               fv_sub_d = fv_sub_q + YW'(1);
            end
         end else begin
            fv_act_d = 1'b0;
         end
      end else begin
         fv_act_d = fv_act_q;
      end

      if (fetch_go_s) begin
         sh_line_d = fv_act_d;
         sh_row_d  = fv_row_d;
         sh_sub_d  = fv_sub_d;
         if (fv_act_d) addr_d   = fv_row_d;
         else          shadow_d = '0;
      end else if (accept_s) begin
         shadow_d = mem_if.row_data;
      end else if (deadline_s) begin
         shadow_d = '0;
      end else begin
         shadow_d = shadow_q;
      end

      if (line_start_s) begin
         act_line_d = sh_line_q;
         act_row_d  = sh_row_q;
         act_sub_d  = sh_sub_q;
         if (accept_s)                  act_d = mem_if.row_data;
         else if (state_q == ST_WAIT)   act_d = '0;
         else                           act_d = shadow_q;
      end else begin
         act_d = act_q;
      end
   end

   // Pixel pipeline stage 1 inputs, stage 2 colour, frame/blink counters, sticky error
   always_comb begin
      if (hc_s == X_LO) begin
         cur_col_s  = '0;
         cur_subx_s = '0;
      end else begin
         cur_col_s  = col_q;
         cur_subx_s = subx_q;
      end
      if (cur_subx_s == SUBX_LAST) begin
         col_d  = cur_col_s + CW'(1);
         subx_d = '0;
      end else begin
         col_d  = cur_col_s;
         subx_d = cur_subx_s + XW'(1);
      end

      s1_bright_d = bright_i;
      s1_inb_d    = act_line_q && (hc_s >= X_LO) && (hc_s < X_HI);
      if (s1_inb_d) s1_cell_d = act_q[cur_col_s];
      else          s1_cell_d = 1'b0;
      s1_edge_d   = GRID_EN && ((cur_subx_s == '0) || (act_sub_q == '0));
      s1_clr_d    = clear_mask_i[act_row_q] && blink_q;

      if (!s1_bright_q)                  colour_d = 24'h000000;
      else if (!s1_inb_q)                colour_d = BG_COLOR;
      else if (s1_cell_q && !s1_clr_q)   colour_d = ON_COLOR;
      else if (s1_edge_q)                colour_d = GRID_COLOR;
      else                               colour_d = OFF_COLOR;

      if (line_start_s && (vcount_i == 10'd0)) begin
         if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            blink_d = !blink_q;
         end else begin
            frame_d = frame_q + FW'(1);
            blink_d = blink_q;
         end
      end else begin
         frame_d = frame_q;
         blink_d = blink_q;
      end

      err_d = err_q | deadline_s;
   end

   // Datapath registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fv_act_q    <= 1'b0;
         fv_row_q    <= '0;
         fv_sub_q    <= '0;
         addr_q      <= '0;
         shadow_q    <= '0;
         sh_line_q   <= 1'b0;
         sh_row_q    <= '0;
         sh_sub_q    <= '0;
         act_q       <= '0;
         act_line_q  <= 1'b0;
         act_row_q   <= '0;
         act_sub_q   <= '0;
         err_q       <= 1'b0;
         col_q       <= '0;
         subx_q      <= '0;
         frame_q     <= '0;
         blink_q     <= 1'b0;
         s1_bright_q <= 1'b0;
         s1_inb_q    <= 1'b0;
         s1_cell_q   <= 1'b0;
         s1_edge_q   <= 1'b0;
         s1_clr_q    <= 1'b0;
         colour_q    <= 24'h000000;
      end else begin
         fv_act_q    <= fv_act_d;
         fv_row_q    <= fv_row_d;
         fv_sub_q    <= fv_sub_d;
         addr_q      <= addr_d;
         shadow_q    <= shadow_d;
         sh_line_q   <= sh_line_d;
         sh_row_q    <= sh_row_d;
         sh_sub_q    <= sh_sub_d;
         act_q       <= act_d;
         act_line_q  <= act_line_d;
         act_row_q   <= act_row_d;
         act_sub_q   <= act_sub_d;
         err_q       <= err_d;
         col_q       <= col_d;
         subx_q      <= subx_d;
         frame_q     <= frame_d;
         blink_q     <= blink_d;
         s1_bright_q <= s1_bright_d;
         s1_inb_q    <= s1_inb_d;
         s1_cell_q   <= s1_cell_d;
         s1_edge_q   <= s1_edge_d;
         s1_clr_q    <= s1_clr_d;
         colour_q    <= colour_d;
      end
   end
endmodule
